// File: rtl/sblk_pkg.sv
// sblk_pkg: shared types and constants for the SuperBlock loop sequencer.
//   - field widths of the layer configuration
//   - sblk_cfg_t: configuration latched on start
//   - sblk_seq_state_e: sequencer state type plus its state constants
//   - sblk_kk(): kernel area (kernel_m1 + 1)^2
package sblk_pkg;

    localparam int unsigned KER_BITS    = 3;
    localparam int unsigned STRIDE_BITS = 2;
    localparam int unsigned NWIN_BITS   = 5;
    localparam int unsigned NOFM_BITS   = 4;
    localparam int unsigned OFF_BITS    = 6;
    localparam int unsigned KER_LINES   = 8;
    localparam int unsigned KK_BITS     = 7;

    // Plain vector states keep the encoding visible to legacy tooling.
    typedef logic [1:0] sblk_seq_state_e;
    localparam sblk_seq_state_e StIdle  = 2'd0;
    localparam sblk_seq_state_e StRun   = 2'd1;
    localparam sblk_seq_state_e StDrain = 2'd2;

    typedef struct packed {
        logic [KER_BITS-1:0]                 kernel_m1;
        logic [STRIDE_BITS-1:0]              stride_m1;
        logic [NWIN_BITS-1:0]                nwin_m1;
        logic [NOFM_BITS-1:0]                nofm_m1;
        logic [KER_LINES-1:0][OFF_BITS-1:0]  kerline_off;
        logic [KER_LINES-1:0]                actupd;
    } sblk_cfg_t;

    // Largest kernel is 8x8 = 64, which fits the 7-bit result.
    function automatic logic [KK_BITS-1:0] sblk_kk(input logic [KER_BITS-1:0] kernel_m1);
        logic [KK_BITS-1:0] k;
        k = KK_BITS'(kernel_m1) + KK_BITS'(1);
        return k * k;
    endfunction

endpackage

// File: rtl/sblk_seq_if.sv
// sblk_seq_if: job control and address bus between the SuperBlock datapath and its sequencer.
//   master: datapath side (drives start/cfg, consumes addresses and enables)
//   slave : sequencer side (sblk_seq)
interface sblk_seq_if
    import sblk_pkg::*;
#(
    parameter int unsigned ACTADDR_BIT = 6,
    parameter int unsigned WADDR_BIT   = 10,
    parameter int unsigned PBADDR_BIT  = 10
);

    logic                            start;
    logic [KER_BITS-1:0]             cfg_kernel_m1;
    logic [STRIDE_BITS-1:0]          cfg_stride_m1;
    logic [NWIN_BITS-1:0]            cfg_nwin_m1;
    logic [NOFM_BITS-1:0]            cfg_nofm_m1;
    logic [KER_LINES*OFF_BITS-1:0]   cfg_kerline_off;
    logic [KER_LINES-1:0]            cfg_actupd;

    logic                            busy;
    logic                            done;
    logic                            rd_valid;
    logic [ACTADDR_BIT-1:0]          act_rd_addr0;
    logic [ACTADDR_BIT-1:0]          act_rd_addr1;
    logic [WADDR_BIT-1:0]            w_rd_addr;
    logic                            act_update;
    logic                            psum_first;
    logic [PBADDR_BIT-1:0]           psum_rd_addr;
    logic                            psum_rd_en;
    logic [PBADDR_BIT-1:0]           psum_wr_addr;
    logic                            psum_wr_en;

    modport master (
        output start, cfg_kernel_m1, cfg_stride_m1, cfg_nwin_m1, cfg_nofm_m1,
               cfg_kerline_off, cfg_actupd,
        input  busy, done, rd_valid, act_rd_addr0, act_rd_addr1, w_rd_addr, act_update,
               psum_first, psum_rd_addr, psum_rd_en, psum_wr_addr, psum_wr_en
    );

    modport slave (
        input  start, cfg_kernel_m1, cfg_stride_m1, cfg_nwin_m1, cfg_nofm_m1,
               cfg_kerline_off, cfg_actupd,
        output busy, done, rd_valid, act_rd_addr0, act_rd_addr1, w_rd_addr, act_update,
               psum_first, psum_rd_addr, psum_rd_en, psum_wr_addr, psum_wr_en
    );

endinterface

// File: rtl/sblk_delay_line.sv
// sblk_delay_line: resettable shift register, DEPTH stages of WIDTH bits.
//   clk_l, rst_n : clock, async active-low reset (clears every stage)
//   in_data      : entry entering stage 0; its MSB is the entry's valid flag
//   out_data     : entry leaving the last stage (DEPTH cycles after entry)
//   empty        : no valid entry behind the output stage, i.e. the line is
//                  clear once the current output retires
module sblk_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_l,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data,
    output logic             empty
);

    logic [DEPTH-1:0][WIDTH-1:0] line_q;

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
        end else begin
            line_q[0] <= in_data;
            for (int i = 1; i < int'(DEPTH); i++) begin
                line_q[i] <= line_q[i-1];
            end
        end
    end

    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            if (line_q[i][WIDTH-1]) begin
                empty = 1'b0;
            end
        end
    end

    assign out_data = line_q[DEPTH-1];

endmodule

// File: rtl/sblk_seq.sv
// sblk_seq: loop sequencer for one SuperBlock, clk_l domain only.
//   clk_l, rst_n : clock, async active-low reset
//   bus (slave)  : start/cfg in; busy, done, activation/weight/psum addresses and
//                  enables out. Loop nest innermost first: kerw, win, ofm, kerh.
module sblk_seq
    import sblk_pkg::*;
#(
    parameter int unsigned ACTADDR_BIT = 6,
    parameter int unsigned WADDR_BIT   = 10,
    parameter int unsigned PBADDR_BIT  = 10,
    parameter int unsigned PSUM_LAT    = 6
) (
    input  logic    clk_l,
    input  logic    rst_n,
    sblk_seq_if.slave bus
);

    sblk_seq_state_e        state_q, state_d;
    sblk_cfg_t              cfg_q, cfg_d;
    logic [KK_BITS-1:0]     kk_q, kk_d;
    logic [KER_BITS-1:0]    kerw_q, kerw_d, kerh_q, kerh_d;
    logic [NWIN_BITS-1:0]   win_q, win_d;
    logic [NOFM_BITS-1:0]   ofm_q, ofm_d;
    logic                   done_q, done_d;

    logic                   run;
    logic                   last_kerw, last_win, last_ofm, last_kerh;
    logic                   line_empty;
    logic [PBADDR_BIT:0]    wr_line_out;

    logic [31:0]            stride;
    logic [ACTADDR_BIT-1:0] act0, act1;
    logic [WADDR_BIT-1:0]   w_addr;
    logic [PBADDR_BIT-1:0]  pidx;

    logic                   rd_valid_q, prd_en_q, wr_pend_q, act_upd_q, first_q;
    logic [ACTADDR_BIT-1:0] act0_q, act1_q;
    logic [WADDR_BIT-1:0]   w_q;
    logic [PBADDR_BIT-1:0]  pidx_q;

    assign run       = (state_q == StRun);
    assign last_kerw = (kerw_q == cfg_q.kernel_m1);
    assign last_win  = (win_q  == cfg_q.nwin_m1);
    assign last_ofm  = (ofm_q  == cfg_q.nofm_m1);
    assign last_kerh = (kerh_q == cfg_q.kernel_m1);

    // Next state and loop counters.
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        kk_d    = kk_q;
        kerw_d  = kerw_q;
        win_d   = win_q;
        ofm_d   = ofm_q;
        kerh_d  = kerh_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    cfg_d.kernel_m1   = bus.cfg_kernel_m1;
                    cfg_d.stride_m1   = bus.cfg_stride_m1;
                    cfg_d.nwin_m1     = bus.cfg_nwin_m1;
                    cfg_d.nofm_m1     = bus.cfg_nofm_m1;
                    cfg_d.kerline_off = bus.cfg_kerline_off;
                    cfg_d.actupd      = bus.cfg_actupd;
                    kk_d              = sblk_kk(bus.cfg_kernel_m1);
                    kerw_d            = '0;
                    win_d             = '0;
                    ofm_d             = '0;
                    kerh_d            = '0;
                    state_d           = StRun;
                end
            end
            StRun: begin
                if (!last_kerw) begin
                    kerw_d = kerw_q + KER_BITS'(1);
                end else begin
                    kerw_d = '0;
                    if (!last_win) begin
                        win_d = win_q + NWIN_BITS'(1);
                    end else begin
                        win_d = '0;
                        if (!last_ofm) begin
                            ofm_d = ofm_q + NOFM_BITS'(1);
                        end else begin
                            ofm_d = '0;
                            if (!last_kerh) begin
                                kerh_d = kerh_q + KER_BITS'(1);
                            end else begin
                                kerh_d  = '0;
                                state_d = StDrain;
                            end
                        end
                    end
                end
            end
            StDrain: begin
                // wr_pend_q must be clear too: the last step may still be entering the line.
                if (!wr_pend_q && line_empty) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Address arithmetic wraps modulo the port widths.
    always_comb begin
        stride = 32'(cfg_q.stride_m1) + 32'd1;
        act0   = ACTADDR_BIT'(32'd2 * 32'(win_q) * stride + 32'(kerw_q));
        act1   = ACTADDR_BIT'((32'd2 * 32'(win_q) + 32'd1) * stride + 32'(kerw_q));
        w_addr = WADDR_BIT'(32'(cfg_q.kerline_off[kerh_q]) + 32'(kerw_q)
                            + 32'(ofm_q) * 32'(kk_q));
        pidx   = PBADDR_BIT'(32'(ofm_q) * (32'(cfg_q.nwin_m1) + 32'd1) + 32'(win_q));
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cfg_q   <= '0;
            kk_q    <= '0;
            kerw_q  <= '0;
            win_q   <= '0;
            ofm_q   <= '0;
            kerh_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            kk_q    <= kk_d;
            kerw_q  <= kerw_d;
            win_q   <= win_d;
            ofm_q   <= ofm_d;
            kerh_q  <= kerh_d;
            done_q  <= done_d;
        end
    end

    // Registered step outputs; the step presented is the one the counters held last cycle.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            prd_en_q   <= 1'b0;
            wr_pend_q  <= 1'b0;
            act_upd_q  <= 1'b0;
            first_q    <= 1'b0;
            act0_q     <= '0;
            act1_q     <= '0;
            w_q        <= '0;
            pidx_q     <= '0;
        end else begin
            rd_valid_q <= run;
            prd_en_q   <= run && (kerw_q == '0);
            wr_pend_q  <= run && last_kerw;
            act_upd_q  <= run && cfg_q.actupd[kerh_q];
            first_q    <= run && (kerh_q == '0);
            if (run) begin
                act0_q <= act0;
                act1_q <= act1;
                w_q    <= w_addr;
                pidx_q <= pidx;
            end
        end
    end

    sblk_delay_line #(
        .DEPTH (PSUM_LAT),
        .WIDTH (PBADDR_BIT + 1)
    ) u_wr_delay (
        .clk_l    (clk_l),
        .rst_n    (rst_n),
        .in_data  ({wr_pend_q, pidx_q}),
        .out_data (wr_line_out),
        .empty    (line_empty)
    );

    assign bus.busy         = (state_q != StIdle);
    assign bus.done         = done_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.act_rd_addr0 = act0_q;
    assign bus.act_rd_addr1 = act1_q;
    assign bus.w_rd_addr    = w_q;
    assign bus.act_update   = act_upd_q;
    assign bus.psum_first   = first_q;
    assign bus.psum_rd_addr = pidx_q;
    assign bus.psum_rd_en   = prd_en_q;
    assign bus.psum_wr_en   = wr_line_out[PBADDR_BIT];
    assign bus.psum_wr_addr = wr_line_out[PBADDR_BIT-1:0];

endmodule

// File: tb/tb_sblk_seq.sv
// tb_sblk_seq: self-checking bench for sblk_seq. Each job is expanded by a loop-nest
// model into an expected step list; every cycle of the job is compared against it.
module tb_sblk_seq;
    import sblk_pkg::*;

    localparam int unsigned ACTADDR_BIT = 6;
    localparam int unsigned WADDR_BIT   = 10;
    localparam int unsigned PBADDR_BIT  = 10;
    localparam int unsigned PSUM_LAT    = 6;

    logic clk_l = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk_l = ~clk_l;

    sblk_seq_if #(
        .ACTADDR_BIT (ACTADDR_BIT),
        .WADDR_BIT   (WADDR_BIT),
        .PBADDR_BIT  (PBADDR_BIT)
    ) bus ();

    sblk_seq #(
        .ACTADDR_BIT (ACTADDR_BIT),
        .WADDR_BIT   (WADDR_BIT),
        .PBADDR_BIT  (PBADDR_BIT),
        .PSUM_LAT    (PSUM_LAT)
    ) dut (
        .clk_l (clk_l),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          km1, sm1, nwm1, nfm1;
        logic [47:0] off;
        logic [7:0]  upd;
    } job_t;

    typedef struct {
        int a0, a1, w, upd, first, rd, p, wr;
    } step_t;

    typedef struct {
        job_t job;
        int   exp_n;
        int   exp_wr;
    } vec_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    step_t exp_q[$];
    int    obs_a0[$], obs_a1[$], obs_w[$], obs_first[$], obs_upd[$], obs_wra[$];
    int    got_n, got_wr, got_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic job_t mk_job(input int km1, input int sm1, input int nwm1,
                                    input int nfm1, input logic [47:0] off,
                                    input logic [7:0] upd);
        job_t j;
        j.km1 = km1; j.sm1 = sm1; j.nwm1 = nwm1; j.nfm1 = nfm1; j.off = off; j.upd = upd;
        return j;
    endfunction

    // Loop nest straight from the job description, kerw innermost.
    function automatic void build_model(input job_t j);
        int    k, s, kk, nw;
        step_t st;
        k  = j.km1 + 1;
        s  = j.sm1 + 1;
        kk = k * k;
        nw = j.nwm1 + 1;
        exp_q.delete();
        for (int kh = 0; kh < k; kh++)
            for (int of = 0; of <= j.nfm1; of++)
                for (int wi = 0; wi < nw; wi++)
                    for (int kw = 0; kw < k; kw++) begin
                        st.a0    = (2 * wi * s + kw) % (2 ** ACTADDR_BIT);
                        st.a1    = ((2 * wi + 1) * s + kw) % (2 ** ACTADDR_BIT);
                        st.w     = (int'(j.off[6*kh +: 6]) + kw + of * kk) % (2 ** WADDR_BIT);
                        st.upd   = int'(j.upd[kh]);
                        st.first = (kh == 0) ? 1 : 0;
                        st.rd    = (kw == 0) ? 1 : 0;
                        st.p     = (of * nw + wi) % (2 ** PBADDR_BIT);
                        st.wr    = (kw == k - 1) ? 1 : 0;
                        exp_q.push_back(st);
                    end
    endfunction

    task automatic apply_cfg(input job_t j);
        bus.cfg_kernel_m1   = 3'(j.km1);
        bus.cfg_stride_m1   = 2'(j.sm1);
        bus.cfg_nwin_m1     = 5'(j.nwm1);
        bus.cfg_nofm_m1     = 4'(j.nfm1);
        bus.cfg_kerline_off = j.off;
        bus.cfg_actupd      = j.upd;
    endtask

    // Must be entered right after a falling edge with the DUT idle. Leaves at the done cycle.
    task automatic run_job(input job_t j, input int ign_at);
        int          n, d, si, wi;
        logic        ev, e_rd, e_wr;
        logic [23:0] fa, fe;
        logic [9:0]  ra, re, wa, we;
        logic [63:0] act, exp;
        step_t       es;
        build_model(j);
        n = exp_q.size();
        d = n + PSUM_LAT + 2;
        obs_a0.delete(); obs_a1.delete(); obs_w.delete();
        obs_first.delete(); obs_upd.delete(); obs_wra.delete();
        got_n = 0; got_wr = 0; got_done = 0;
        apply_cfg(j);
        bus.start = 1'b1;
        for (int c = 1; c <= d; c++) begin
            @(negedge clk_l);
            si = c - 2;
            wi = c - 2 - int'(PSUM_LAT);
            ev = (si >= 0) && (si < n);
            fe = '0; fa = '0; re = '0; ra = '0; we = '0; wa = '0; e_rd = 1'b0; e_wr = 1'b0;
            if (ev) begin
                es   = exp_q[si];
                fe   = {6'(es.a0), 6'(es.a1), 10'(es.w), 1'(es.upd), 1'(es.first)};
                fa   = {bus.act_rd_addr0, bus.act_rd_addr1, bus.w_rd_addr,
                        bus.act_update, bus.psum_first};
                e_rd = (es.rd != 0);
                if (e_rd) begin
                    re = 10'(es.p);
                    ra = bus.psum_rd_addr;
                end
            end
            if ((wi >= 0) && (wi < n)) begin
                e_wr = (exp_q[wi].wr != 0);
                if (e_wr) begin
                    we = 10'(exp_q[wi].p);
                    wa = bus.psum_wr_addr;
                end
            end
            act = {15'b0, bus.busy, bus.done, bus.rd_valid, fa, bus.psum_rd_en, ra,
                   bus.psum_wr_en, wa};
            exp = {15'b0, 1'(c < d), 1'(c == d), ev, fe, e_rd, re, e_wr, we};
            check($sformatf("cycle %0d of %0d", c, d), act, exp);
            if (bus.rd_valid === 1'b1) begin
                got_n++;
                obs_a0.push_back(int'(bus.act_rd_addr0));
                obs_a1.push_back(int'(bus.act_rd_addr1));
                obs_w.push_back(int'(bus.w_rd_addr));
                obs_first.push_back(int'(bus.psum_first));
                obs_upd.push_back(int'(bus.act_update));
            end
            if (bus.psum_wr_en === 1'b1) begin
                got_wr++;
                obs_wra.push_back(int'(bus.psum_wr_addr));
            end
            if (bus.done === 1'b1) got_done = c;
            bus.start = (ign_at > 0) && (c == ign_at);
            // Inputs change after acceptance; the latched job must not follow them.
            if (c == 1) begin
                bus.cfg_kernel_m1   = 3'($urandom);
                bus.cfg_stride_m1   = 2'($urandom);
                bus.cfg_nwin_m1     = 5'($urandom);
                bus.cfg_nofm_m1     = 4'($urandom);
                bus.cfg_kerline_off = {$urandom, $urandom};
                bus.cfg_actupd      = 8'($urandom);
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic check_list(input string name, input int obs[$], input int exp[$]);
        check({name, "_len"}, 64'(obs.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < obs.size(); i++)
            check($sformatf("%s[%0d]", name, i), 64'(obs[i]), 64'(exp[i]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        job_t basic, strd, rj;
        int   e_a0[$], e_a1[$], e_w[$], e_wra[$], e_first[$], e_upd[$];

        basic = mk_job(2, 0, 1, 0, 48'd24768, 8'b0000_0110);   // offsets {0,3,6}
        strd  = mk_job(1, 1, 0, 1, 48'd128, 8'b0000_0001);     // offsets {0,2}

        bus.start = 1'b0;
        apply_cfg(mk_job(0, 0, 0, 0, 48'd0, 8'd0));
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk_l);
        check("reset_outputs",
              {15'b0, bus.busy, bus.done, bus.rd_valid, bus.act_rd_addr0, bus.act_rd_addr1,
               bus.w_rd_addr, bus.act_update, bus.psum_first, bus.psum_rd_en, bus.psum_rd_addr,
               bus.psum_wr_en, bus.psum_wr_addr}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk_l);
        check("idle_after_reset", {61'b0, bus.busy, bus.done, bus.rd_valid}, 64'd0);

        // Table: expected step count N = K*(nwin+1)*(nofm+1)*K and writes N/K.
        vecs[0] = '{basic, 18, 6};
        vecs[1] = '{strd, 8, 4};
        vecs[2] = '{mk_job(0, 0, 0, 0, 48'd0, 8'd0), 1, 1};
        vecs[3] = '{mk_job(7, 3, 31, 0, 48'hFFF_FFFF_FFFF, 8'hA5), 2048, 256};
        vecs[4] = '{mk_job(0, 2, 3, 2, 48'd63, 8'hFF), 12, 12};
        for (int i = 0; i < 5; i++) begin
            run_job(vecs[i].job, 0);
            check($sformatf("vec%0d_n", i), 64'(got_n), 64'(vecs[i].exp_n));
            check($sformatf("vec%0d_wr", i), 64'(got_wr), 64'(vecs[i].exp_wr));
            check($sformatf("vec%0d_done", i), 64'(got_done),
                  64'(vecs[i].exp_n + int'(PSUM_LAT) + 2));
            @(negedge clk_l);
        end

        // Basic addressing and psum flags, with a start pulse during RUN.
        run_job(basic, 5);
        e_a0 = '{0,1,2,2,3,4, 0,1,2,2,3,4, 0,1,2,2,3,4};
        e_a1 = '{1,2,3,3,4,5, 1,2,3,3,4,5, 1,2,3,3,4,5};
        e_w  = '{0,1,2,0,1,2, 3,4,5,3,4,5, 6,7,8,6,7,8};
        e_wra   = '{0,1,0,1,0,1};
        e_first = '{1,1,1,1,1,1, 0,0,0,0,0,0, 0,0,0,0,0,0};
        e_upd   = '{0,0,0,0,0,0, 1,1,1,1,1,1, 1,1,1,1,1,1};
        check_list("basic_act0", obs_a0, e_a0);
        check_list("basic_act1", obs_a1, e_a1);
        check_list("basic_w", obs_w, e_w);
        check_list("basic_wr_addr", obs_wra, e_wra);
        check_list("basic_first", obs_first, e_first);
        check_list("basic_actupd", obs_upd, e_upd);

        // Back-to-back: start asserted in the done cycle.
        run_job(strd, 0);
        e_a0 = '{0,1,0,1,0,1,0,1};
        e_a1 = '{2,3,2,3,2,3,2,3};
        e_w  = '{0,1,4,5,2,3,6,7};
        check_list("stride_act0", obs_a0, e_a0);
        check_list("stride_act1", obs_a1, e_a1);
        check_list("stride_w", obs_w, e_w);
        @(negedge clk_l);

        // Reset in the middle of RUN.
        apply_cfg(basic);
        bus.start = 1'b1;
        @(negedge clk_l);
        bus.start = 1'b0;
        repeat (8) @(negedge clk_l);
        rst_n = 1'b0;
        #1;
        check("reset_mid_outputs",
              {15'b0, bus.busy, bus.done, bus.rd_valid, bus.act_rd_addr0, bus.act_rd_addr1,
               bus.w_rd_addr, bus.act_update, bus.psum_first, bus.psum_rd_en, bus.psum_rd_addr,
               bus.psum_wr_en, bus.psum_wr_addr}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_l);
            check("reset_hold", {61'b0, bus.busy, bus.done, bus.psum_wr_en}, 64'd0);
        end
        rst_n = 1'b1;
        repeat (PSUM_LAT + 2) begin
            @(negedge clk_l);
            check("post_reset_quiet", {61'b0, bus.busy, bus.done, bus.psum_wr_en}, 64'd0);
        end
        run_job(basic, 0);
        e_a0 = '{0,1,2,2,3,4, 0,1,2,2,3,4, 0,1,2,2,3,4};
        check_list("restart_act0", obs_a0, e_a0);
        @(negedge clk_l);

        // Randomised jobs against the model.
        for (int r = 0; r < 12; r++) begin
            rj = mk_job($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7),
                        $urandom_range(0, 3), {$urandom, $urandom}, 8'($urandom));
            run_job(rj, (r % 3 == 0) ? 4 : 0);
            check($sformatf("rand%0d_done", r), 64'(got_done),
                  64'((rj.km1 + 1) * (rj.km1 + 1) * (rj.nwm1 + 1) * (rj.nfm1 + 1)
                      + int'(PSUM_LAT) + 2));
            if (r % 2 == 0) @(negedge clk_l);
        end
        @(negedge clk_l);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
